ramp_counter_gen: RTL and testbench

RAMP_COUNTER_GEN -- requirements
Module: ramp_counter_gen

---
 rtl/ramp_counter_gen.sv | 115 +++++++++++
 tb/tb_ramp_counter_gen.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ramp_counter_gen.sv
// Single-slope ADC ramp sequencer: settle the analog ramp, sweep the DAC code, and report
// whether the comparator tripped before the ramp ran out.
module ramp_counter_gen #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned STOP_ON_COMP  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             comp,
  output logic [WIDTH-1:0] counter,
  output logic             ramp_rst,
  output logic             ramp_en,
  output logic             busy,
  output logic             done,
  output logic             overrange
);

  typedef enum logic [1:0] {StIdle, StSettle, StRamp, StDone} state_e;

  localparam logic [WIDTH-1:0] CntMax     = {WIDTH{1'b1}};
  localparam logic [7:0]       SettleLast = 8'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic [7:0]       settle_cnt_q, settle_cnt_d;
  logic             prev_comp_q, prev_comp_d;
  logic             edge_seen_q, edge_seen_d;
  logic             overrange_q, overrange_d;
  logic             comp_edge;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      counter_q    <= '0;
      settle_cnt_q <= '0;
      prev_comp_q  <= 1'b0;
      edge_seen_q  <= 1'b0;
      overrange_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      settle_cnt_q <= settle_cnt_d;
      prev_comp_q  <= prev_comp_d;
      edge_seen_q  <= edge_seen_d;
      overrange_q  <= overrange_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    settle_cnt_d = settle_cnt_q;
    prev_comp_d  = prev_comp_q;
    edge_seen_d  = edge_seen_q;
    overrange_d  = overrange_q;
    comp_edge    = 1'b0;

    unique case (state_q)
      StIdle: begin
        counter_d = '0;
        if (start) begin
          state_d      = StSettle;
          settle_cnt_d = '0;
          prev_comp_d  = 1'b1;  // comp already high at ramp start must not look like an edge
          edge_seen_d  = 1'b0;
        end
      end
      StSettle: begin
        counter_d = '0;
        if (settle_cnt_q == SettleLast) begin
          state_d = StRamp;
        end else begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end
      StRamp: begin
        comp_edge   = comp & ~prev_comp_q;
        prev_comp_d = comp;
        if (comp_edge) begin
          edge_seen_d = 1'b1;
        end
        if (((STOP_ON_COMP != 0) && comp_edge) || (counter_q == CntMax)) begin
          state_d     = StDone;
          overrange_d = ~(edge_seen_q | comp_edge);
        end else begin
          counter_d = counter_q + 1'b1;
        end
      end
      StDone: begin
        if (cont) begin
          state_d      = StSettle;
          counter_d    = '0;
          settle_cnt_d = '0;
          prev_comp_d  = 1'b1;
          edge_seen_d  = 1'b0;
        end else begin
          state_d   = StIdle;
          counter_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign counter   = counter_q;
  assign ramp_rst  = (state_q == StSettle);
  assign ramp_en   = (state_q == StRamp);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign overrange = overrange_q;

endmodule

// File: tb/tb_ramp_counter_gen.sv
// Directed bench: free-running ramp (dut0) and comparator-stop ramp (dut1) share stimulus.
module tb_ramp_counter_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic       comp = 1'b0;
  logic [7:0] counter0, counter1;
  logic       ramp_rst0, ramp_en0, busy0, done0, overrange0;
  logic       ramp_rst1, ramp_en1, busy1, done1, overrange1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ramp_counter_gen #(.WIDTH(8), .SETTLE_CYCLES(4), .STOP_ON_COMP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .comp(comp),
    .counter(counter0), .ramp_rst(ramp_rst0), .ramp_en(ramp_en0), .busy(busy0),
    .done(done0), .overrange(overrange0)
  );

  ramp_counter_gen #(.WIDTH(8), .SETTLE_CYCLES(4), .STOP_ON_COMP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .comp(comp),
    .counter(counter1), .ramp_rst(ramp_rst1), .ramp_en(ramp_en1), .busy(busy1),
    .done(done1), .overrange(overrange1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle 1 is the first SETTLE cycle after the edge that samples start.
  task automatic run_conv(input string tag, input int comp_at, input bit comp_hold,
                          input int start_again,
                          input int d0_cyc, input int d0_cnt, input bit d0_ovr,
                          input int d1_cyc, input int d1_cnt, input bit d1_ovr);
    int n = 1;
    int rst_cnt = 0;
    int en_cnt = 0;
    bit seen0 = 0;
    bit seen1 = 0;
    bit wrap = 0;
    logic [7:0] last0 = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!(seen0 && seen1) && n <= 400) begin
      comp  = comp_hold || (comp_at >= 0 && n >= comp_at);
      start = (n == start_again);
      if (ramp_rst0) rst_cnt++;
      if (ramp_en0) begin
        en_cnt++;
        if (last0 == 8'd255 && counter0 == 8'd0) wrap = 1;
        last0 = counter0;
      end
      if (done0 && !seen0) begin
        seen0 = 1;
        check_eq({tag, "_d0_cycle"}, n, d0_cyc);
        check_eq({tag, "_d0_counter"}, counter0, d0_cnt);
        check_eq({tag, "_d0_ovr"}, overrange0, d0_ovr);
      end
      if (done1 && !seen1) begin
        seen1 = 1;
        check_eq({tag, "_d1_cycle"}, n, d1_cyc);
        check_eq({tag, "_d1_counter"}, counter1, d1_cnt);
        check_eq({tag, "_d1_ovr"}, overrange1, d1_ovr);
      end
      tick();
      n++;
    end
    start = 1'b0;
    comp  = 1'b0;
    check_eq({tag, "_both_done"}, {31'd0, seen0 & seen1}, 1);
    check_eq({tag, "_settle_len"}, rst_cnt, 4);
    check_eq({tag, "_ramp_len"}, en_cnt, 256);
    check_eq({tag, "_no_wrap"}, {31'd0, wrap}, 0);
    check_eq({tag, "_done_pulse"}, done0, 0);
    check_eq({tag, "_idle_busy"}, busy0, 0);
    check_eq({tag, "_idle_counter"}, counter0, 0);
    check_eq({tag, "_ovr_held"}, overrange0, d0_ovr);
    tick();
    tick();
  endtask

  initial begin
    int n;
    int done_cnt0, done_cnt1, busy_gaps;
    int first_done, second_done;
    bit spurious;

    tick();
    check_eq("reset_busy", {busy0, busy1}, 0);
    check_eq("reset_counter", counter0, 0);
    check_eq("reset_outs", {ramp_rst0, ramp_en0, done0, overrange0}, 0);
    rst = 1'b1;
    tick();
    tick();
    check_eq("idle_no_start", busy0, 0);

    // comp at counter 100 (cycle 105); stray start mid-ramp is ignored
    run_conv("cmp100", 105, 1'b0, 50, 261, 255, 1'b0, 106, 100, 1'b0);
    run_conv("cmp37", 42, 1'b0, -1, 261, 255, 1'b0, 43, 37, 1'b0);
    run_conv("cmp255", 260, 1'b0, -1, 261, 255, 1'b0, 261, 255, 1'b0);
    run_conv("nocmp", -1, 1'b0, -1, 261, 255, 1'b1, 261, 255, 1'b1);
    run_conv("cmphigh", -1, 1'b1, -1, 261, 255, 1'b1, 261, 255, 1'b1);

    // Abort at counter 50, check outputs drop before the next edge
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 55; i++) tick();
    check_eq("abort_pre_counter", counter0, 50);
    check_eq("abort_pre_en", ramp_en0, 1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("abort_counter", {counter0, counter1}, 0);
    check_eq("abort_outs0", {ramp_rst0, ramp_en0, busy0, done0, overrange0}, 0);
    check_eq("abort_outs1", {ramp_rst1, ramp_en1, busy1, done1, overrange1}, 0);
    tick();
    rst = 1'b1;
    spurious = 0;
    for (int i = 0; i < 10; i++) begin
      if (done0 || done1 || busy0 || busy1) spurious = 1;
      tick();
    end
    check_eq("abort_no_done", {31'd0, spurious}, 0);
    run_conv("restart", 105, 1'b0, -1, 261, 255, 1'b0, 106, 100, 1'b0);

    // Continuous mode: back-to-back conversions, drop cont during the second
    cont = 1'b1;
    comp = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    done_cnt0 = 0;
    done_cnt1 = 0;
    busy_gaps = 0;
    first_done = 0;
    second_done = 0;
    n = 1;
    while (done_cnt0 < 2 && n <= 700) begin
      if (n == 300) cont = 1'b0;
      if (!busy0) busy_gaps++;
      if (done1) done_cnt1++;
      if (done0) begin
        done_cnt0++;
        if (done_cnt0 == 1) first_done = n;
        else second_done = n;
      end
      tick();
      n++;
    end
    check_eq("cont_first_done", first_done, 261);
    check_eq("cont_second_done", second_done, 522);
    check_eq("cont_busy_held", busy_gaps, 0);
    check_eq("cont_dut1_dones", done_cnt1, 2);
    check_eq("cont_to_idle", busy0, 0);
    tick();
    check_eq("cont_stays_idle", {busy0, busy1}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
